egress_meta_queue: RTL and testbench

//  Collects per-port egress packet metadata and queues it for software polling.

---
 rtl/egress_meta_queue.sv | 123 ++++++++++++
 tb/tb_egress_meta_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/egress_meta_queue.sv
// Round-robin merge of per-port egress metadata into a FIFO polled by software.
// Latency: strobe held after E0, pushed at E1, visible on meta_word after E1.
// Backpressure: full FIFO stalls grants; a strobe hitting an occupied holding reg is dropped and counted.
module egress_meta_queue #(
    parameter int NUM_PORTS = 4,
    parameter int META_W    = 24,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          experimenting,
    input  logic [NUM_PORTS-1:0]          egress_meta_valid,
    input  logic [NUM_PORTS*META_W-1:0]   egress_meta,
    input  logic                          interface_out_ack,
    output logic [31:0]                   meta_word,
    output logic [$clog2(DEPTH):0]        queue_count,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + META_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic                 exp_q, ack_q, exp_rise, ack_rise;
    logic [NUM_PORTS-1:0] hold_v;
    logic [META_W-1:0]    hold_d [NUM_PORTS];
    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [1:0]           rr_ptr, grant_idx;
    logic                 grant_vld, push, pop;
    logic [NUM_PORTS-1:0] grant, cap;
    logic [2:0]           ndrop;
    logic [CNT_W:0]       drop_sum;

    function automatic logic [1:0] port_at(input logic [1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_PORTS;
        return s[1:0];
    endfunction

    assign exp_rise = experimenting & ~exp_q;
    assign ack_rise = interface_out_ack & ~ack_q;
    assign push     = grant_vld;
    assign pop      = ack_rise && (queue_count != '0);

    // Grant decision uses pre-pop occupancy, so a full FIFO never pushes on a pop cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant     = '0;
        if (queue_count < FULL_CNT) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!grant_vld && hold_v[port_at(rr_ptr, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = port_at(rr_ptr, k);
                end
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        cap   = '0;
        ndrop = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (egress_meta_valid[i] && experimenting) begin
                if (!hold_v[i] || grant[i]) cap[i] = 1'b1;
                else                        ndrop  = ndrop + 3'd1;
            end
        end
        drop_sum = {1'b0, drop_count} + (CNT_W+1)'(ndrop);
    end

    assign head      = mem[rd_ptr];
    assign meta_word = (queue_count != '0)
                     ? {1'b1, 5'b0, head[EW-1 -: 2], 24'(head[META_W-1:0])}
                     : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            exp_q <= experimenting;
            ack_q <= interface_out_ack;
        end
    end

    // Flush on capture enable rising edge behaves exactly like reset for everything but the edge regs.
    always_ff @(posedge clk) begin
        if (reset || exp_rise) begin
            hold_v      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rr_ptr      <= '0;
            queue_count <= '0;
            drop_count  <= '0;
        end else begin
            hold_v <= (hold_v & ~grant) | cap;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= port_at(grant_idx, 1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   queue_count <= queue_count + (AW+1)'(1);
                2'b01:   queue_count <= queue_count - (AW+1)'(1);
                default: queue_count <= queue_count;
            endcase
            if (ndrop != '0) drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cap[i]) hold_d[i] <= egress_meta[i*META_W +: META_W];
        end
        if (push) mem[wr_ptr] <= {grant_idx, hold_d[grant_idx]};
    end

endmodule

// File: tb/tb_egress_meta_queue.sv
// Scoreboard bench for egress_meta_queue: expected words queued at strobe time, compared at the head before each ack.
// Inputs driven and outputs sampled 1 time unit after the rising clock edge.
module tb_egress_meta_queue;

    localparam int NP = 4;
    localparam int MW = 24;

    logic            clk = 1'b0;
    logic            reset, experimenting, interface_out_ack;
    logic [NP-1:0]   egress_meta_valid;
    logic [NP*MW-1:0] egress_meta;
    logic [31:0]     meta_word;
    logic [4:0]      queue_count;
    logic [15:0]     drop_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    egress_meta_queue #(.NUM_PORTS(NP), .META_W(MW), .DEPTH(16), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .experimenting     (experimenting),
        .egress_meta_valid (egress_meta_valid),
        .egress_meta       (egress_meta),
        .interface_out_ack (interface_out_ack),
        .meta_word         (meta_word),
        .queue_count       (queue_count),
        .drop_count        (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int p, input logic [23:0] d);
        logic [1:0] pp;
        pp = p[1:0];
        return {1'b1, 5'b0, pp, d};
    endfunction

    task automatic strobe1(input int p, input logic [23:0] d, input bit expect_push);
        egress_meta_valid    = '0;
        egress_meta_valid[p] = 1'b1;
        egress_meta[p*MW +: MW] = d;
        if (expect_push) sb.push_back(mk(p, d));
        step();
        egress_meta_valid = '0;
    endtask

    // All ports strobe at once; with rr_ptr at 0 they must drain in port order.
    task automatic strobe_all(input bit expect_push);
        logic [23:0] d;
        for (int p = 0; p < NP; p++) begin
            d = 24'($urandom);
            egress_meta[p*MW +: MW] = d;
            if (expect_push) sb.push_back(mk(p, d));
        end
        egress_meta_valid = '1;
        step();
        egress_meta_valid = '0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        chk(tag, meta_word, e);
        interface_out_ack = 1'b1;
        repeat (3) step();
        interface_out_ack = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("rst_word", meta_word, 32'h0);
        chk("rst_qcnt", 32'(queue_count), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        step();
        reset = 1'b0;
        step();
        sb.delete();
    endtask

    initial begin
        reset             = 1'b1;
        experimenting     = 1'b0;
        interface_out_ack = 1'b0;
        egress_meta_valid = '0;
        egress_meta       = '0;
        do_reset();
        experimenting = 1'b1;
        step();

        // T1: single strobe, two-cycle latency
        strobe1(2, 24'hABCDEF, 1'b1);
        chk("t1_lat_cnt", 32'(queue_count), 0);
        step();
        chk("t1_word", meta_word, 32'h82ABCDEF);
        chk("t1_cnt", 32'(queue_count), 1);

        // T2: held ack pops once; ack on empty is harmless
        pop_check("t2_head");
        chk("t2_word", meta_word, 32'h0);
        chk("t2_cnt", 32'(queue_count), 0);
        interface_out_ack = 1'b1;
        step();
        interface_out_ack = 1'b0;
        step();
        chk("t2_empty_cnt", 32'(queue_count), 0);
        chk("t2_empty_word", meta_word, 32'h0);

        // T3: round-robin order from rr_ptr=0, one push per cycle
        do_reset();
        strobe_all(1'b1);
        chk("t3_cnt0", 32'(queue_count), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_cnt", 32'(queue_count), 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            pop_check("t3_head");
            chk("t3_cnt_pop", 32'(queue_count), 32'(3 - k));
        end

        // T4: full FIFO, hold, drop, pop/refill, simultaneous push+pop
        repeat (4) begin
            strobe_all(1'b1);
            repeat (4) step();
        end
        chk("t4_full", 32'(queue_count), 16);
        strobe1(1, 24'h111111, 1'b1);
        chk("t4_hold_cnt", 32'(queue_count), 16);
        chk("t4_hold_drop", 32'(drop_count), 0);
        strobe1(1, 24'h222222, 1'b0);
        chk("t4_drop", 32'(drop_count), 1);
        chk("t4_drop_cnt", 32'(queue_count), 16);
        chk("t4_head", meta_word, sb.pop_front());
        interface_out_ack = 1'b1;
        step();
        chk("t4_full_pop", 32'(queue_count), 15);
        step();
        chk("t4_refill", 32'(queue_count), 16);
        interface_out_ack = 1'b0;
        step();
        pop_check("t4_head2");
        chk("t4_cnt15", 32'(queue_count), 15);
        strobe1(0, 24'h333333, 1'b1);
        chk("t4_head3", meta_word, sb.pop_front());
        interface_out_ack = 1'b1;
        step();
        chk("t4_pushpop", 32'(queue_count), 15);
        interface_out_ack = 1'b0;
        step();
        for (int k = 0; k < 15; k++) pop_check("t4_drain");
        chk("t4_empty", 32'(queue_count), 0);
        chk("t4_drop_keep", 32'(drop_count), 1);

        // T5: capture disabled, then flush on enable rising edge
        strobe1(3, 24'h444444, 1'b0);
        step();
        chk("t5_cnt1", 32'(queue_count), 1);
        experimenting = 1'b0;
        strobe_all(1'b0);
        step();
        chk("t5_nocap", 32'(queue_count), 1);
        chk("t5_nodrop", 32'(drop_count), 1);
        experimenting     = 1'b1;
        egress_meta_valid = '1;
        step();
        egress_meta_valid = '0;
        chk("t5_flush_word", meta_word, 32'h0);
        chk("t5_flush_cnt", 32'(queue_count), 0);
        chk("t5_flush_drop", 32'(drop_count), 0);
        step();
        chk("t5_flush_ign", 32'(queue_count), 0);

        // T6: drop counter saturation, then reset mid-stream
        repeat (4) begin
            strobe_all(1'b0);
            repeat (4) step();
        end
        chk("t6_full", 32'(queue_count), 16);
        strobe_all(1'b0);
        chk("t6_held_nodrop", 32'(drop_count), 0);
        egress_meta_valid = '1;
        repeat (100) step();
        chk("t6_drop400", 32'(drop_count), 400);
        repeat (16383 - 100) step();
        chk("t6_drop_pre", 32'(drop_count), 32'hFFFC);
        step();
        chk("t6_sat", 32'(drop_count), 32'hFFFF);
        repeat (5) step();
        chk("t6_sat_hold", 32'(drop_count), 32'hFFFF);
        reset = 1'b1;
        step();
        chk("t6_rst_word", meta_word, 32'h0);
        chk("t6_rst_cnt", 32'(queue_count), 0);
        chk("t6_rst_drop", 32'(drop_count), 0);
        reset             = 1'b0;
        egress_meta_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
